// File: rtl/io_disp_pkg.sv
// Shared constants for the out_port 7-segment display: segment codes, FSM encoding
// and the decimal digit table (gfedcba, active-low).
package io_disp_pkg;

    localparam int N_CH = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    // Non-decimal nibbles never come out of the converter; blank them defensively.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern.
module seg7_decode
    import io_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_of_digit(digit);
    end

endmodule

// File: rtl/io_seg_display.sv
// Round-robin decimal display of the three CPU out_ports on six 7-segment digits,
// using one shared 7-step shift-add-3 converter.
module io_seg_display
    import io_disp_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CONV_BITS = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] out_port0,
    input  logic [DATA_W-1:0] out_port1,
    input  logic [DATA_W-1:0] out_port2,
    input  logic              freeze,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5,
    output logic              valid
);

    localparam int CNT_W = $clog2(CONV_BITS);

    logic [1:0]           state;
    logic [1:0]           ch;
    logic [CNT_W-1:0]     cnt;
    logic [CONV_BITS-1:0] bin;
    logic [7:0]           bcd;
    logic                 over;

    logic [DATA_W-1:0]      sel_value;
    logic [3:0]             hi_adj;
    logic [3:0]             lo_adj;
    logic [CONV_BITS+7:0]   shifted;
    logic [6:0]             tens_seg;
    logic [6:0]             ones_seg;
    logic [6:0]             tens_out;
    logic [6:0]             ones_out;

    always_comb begin
        case (ch)
            2'd0:    sel_value = out_port0;
            2'd1:    sel_value = out_port1;
            default: sel_value = out_port2;
        endcase
    end

    // One double-dabble step: correct each BCD nibble, then shift the whole {bcd,bin} left.
    always_comb begin
        hi_adj  = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        lo_adj  = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        shifted = {hi_adj, lo_adj, bin} << 1;
    end

    seg7_decode u_tens (.digit(bcd[7:4]), .seg(tens_seg));
    seg7_decode u_ones (.digit(bcd[3:0]), .seg(ones_seg));

    always_comb begin
        tens_out = over ? SEG_DASH : tens_seg;
        ones_out = over ? SEG_DASH : ones_seg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ch    <= 2'd0;
            cnt   <= '0;
            bin   <= '0;
            bcd   <= '0;
            over  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!freeze) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    bin   <= sel_value[CONV_BITS-1:0];
                    over  <= (sel_value > DATA_W'(99));
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd <= shifted[CONV_BITS+7:CONV_BITS];
                    bin <= shifted[CONV_BITS-1:0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(CONV_BITS - 1)) state <= ST_STORE;
                end
                default: begin
                    if (ch == 2'(N_CH - 1)) begin
                        ch    <= 2'd0;
                        valid <= 1'b1;
                    end else begin
                        ch <= ch + 2'd1;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Both digits of a channel are written together so a pair never shows a torn value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hex0 <= SEG_BLANK;
            hex1 <= SEG_BLANK;
            hex2 <= SEG_BLANK;
            hex3 <= SEG_BLANK;
            hex4 <= SEG_BLANK;
            hex5 <= SEG_BLANK;
        end else if (state == ST_STORE) begin
            case (ch)
                2'd0: begin
                    hex1 <= tens_out;
                    hex0 <= ones_out;
                end
                2'd1: begin
                    hex3 <= tens_out;
                    hex2 <= ones_out;
                end
                default: begin
                    hex5 <= tens_out;
                    hex4 <= ones_out;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_seg_display.sv
// Self-checking bench for io_seg_display: vector table through a scoreboard queue,
// plus hand-timed sequences for reset, snapshot, freeze and mid-conversion reset.
module tb_io_seg_display;

    typedef struct {
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [6:0]  h5;
        logic [6:0]  h4;
        logic [6:0]  h3;
        logic [6:0]  h2;
        logic [6:0]  h1;
        logic [6:0]  h0;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        freeze;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic        valid;

    int   assert_count = 0;
    int   fail_count   = 0;
    vec_t vectors[5];
    vec_t exp_q[$];

    io_seg_display #(.DATA_W(32), .CONV_BITS(7)) dut (
        .clock     (clock),
        .reset     (reset),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .freeze    (freeze),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3),
        .hex4      (hex4),
        .hex5      (hex5),
        .valid     (valid)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkHex(input string tag, input logic [6:0] e5, input logic [6:0] e4,
                            input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        checkValue({tag, " hex5"}, 32'(hex5), 32'(e5));
        checkValue({tag, " hex4"}, 32'(hex4), 32'(e4));
        checkValue({tag, " hex3"}, 32'(hex3), 32'(e3));
        checkValue({tag, " hex2"}, 32'(hex2), 32'(e2));
        checkValue({tag, " hex1"}, 32'(hex1), 32'(e1));
        checkValue({tag, " hex0"}, 32'(hex0), 32'(e0));
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        out_port0 = v.p0;
        out_port1 = v.p1;
        out_port2 = v.p2;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing, expected one entry", tag);
        end else begin
            e = exp_q.pop_front();
            checkHex(tag, e.h5, e.h4, e.h3, e.h2, e.h1, e.h0);
        end
    endtask

    initial begin
        int wait_cnt;

        vectors[0] = '{p0: 32'd99, p1: 32'd100, p2: 32'h0000_0080,
                       h5: 7'h3F, h4: 7'h3F, h3: 7'h3F, h2: 7'h3F, h1: 7'h10, h0: 7'h10};
        vectors[1] = '{p0: 32'd42, p1: 32'd5, p2: 32'd98,
                       h5: 7'h10, h4: 7'h00, h3: 7'h40, h2: 7'h12, h1: 7'h19, h0: 7'h24};
        vectors[2] = '{p0: 32'hFFFF_FFFF, p1: 32'd10, p2: 32'd50,
                       h5: 7'h12, h4: 7'h40, h3: 7'h79, h2: 7'h40, h1: 7'h3F, h0: 7'h3F};
        vectors[3] = '{p0: 32'd0, p1: 32'd61, p2: 32'd87,
                       h5: 7'h00, h4: 7'h78, h3: 7'h02, h2: 7'h79, h1: 7'h40, h0: 7'h40};
        vectors[4] = '{p0: 32'h0000_0163, p1: 32'd1, p2: 32'd33,
                       h5: 7'h30, h4: 7'h30, h3: 7'h40, h2: 7'h79, h1: 7'h3F, h0: 7'h3F};

        reset     = 1'b1;
        freeze    = 1'b0;
        out_port0 = 32'd15;
        out_port1 = 32'd7;
        out_port2 = 32'd0;

        // Asynchronous reset must blank the outputs before the first clock edge.
        #1;
        checkHex("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        checkValue("reset valid", 32'(valid), 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        waitEdges(10);
        checkValue("basic ch0 hex1", 32'(hex1), 32'h79);
        checkValue("basic ch0 hex0", 32'(hex0), 32'h12);
        checkValue("basic ch1 not yet", 32'(hex2), 32'h7F);
        waitEdges(19);
        checkValue("basic valid before pass", 32'(valid), 32'd0);
        waitEdges(1);
        checkValue("basic valid after pass", 32'(valid), 32'd1);
        checkHex("basic", 7'h40, 7'h40, 7'h40, 7'h78, 7'h79, 7'h12);

        $display("[TB] vector table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i]);
            waitEdges(40);
            checkOutput($sformatf("vec%0d", i));
        end
        checkValue("valid sticky", 32'(valid), 32'd1);

        $display("[TB] snapshot sequence");
        @(negedge clock);
        reset = 1'b1;
        out_port0 = 32'd7;
        out_port1 = 32'd42;
        out_port2 = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        waitEdges(14);
        out_port1 = 32'd63;
        waitEdges(6);
        checkValue("snap first hex3", 32'(hex3), 32'h19);
        checkValue("snap first hex2", 32'(hex2), 32'h24);
        waitEdges(30);
        checkValue("snap next hex3", 32'(hex3), 32'h02);
        checkValue("snap next hex2", 32'(hex2), 32'h30);

        $display("[TB] freeze sequence");
        freeze = 1'b1;
        out_port0 = 32'd88;
        out_port1 = 32'd21;
        out_port2 = 32'd100;
        for (int k = 0; k < 10; k++) begin
            waitEdges(10);
            checkHex($sformatf("freeze hold %0d", k), 7'h40, 7'h40, 7'h02, 7'h30, 7'h40, 7'h78);
        end
        freeze = 1'b0;
        waitEdges(30);
        checkHex("freeze release", 7'h3F, 7'h3F, 7'h24, 7'h79, 7'h00, 7'h00);

        $display("[TB] reset mid-conversion");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        waitEdges(24);
        #2;
        reset = 1'b1;
        #1;
        checkHex("midreset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        checkValue("midreset valid", 32'(valid), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_cnt = 0;
        while (hex0 === 7'h7F && wait_cnt < 20) begin
            waitEdges(1);
            wait_cnt++;
        end
        checkValue("restart latency", 32'(wait_cnt), 32'd10);
        checkValue("restart hex1", 32'(hex1), 32'h00);
        checkValue("restart hex0", 32'(hex0), 32'h00);
        checkValue("restart ch1 blank", 32'(hex2), 32'h7F);
        checkValue("restart valid", 32'(valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
